modexp_ctrl: RTL and testbench
==============================

// Module: modexp_ctrl
// PURPOSE
//  Sequencer computing result = M^E mod N by left-to-right square-and-multiply.
//  Owns an internal n x n multiplier; every reduction goes through the shared
//  modulo lookup ROM (address {N-1, product}, registered output, 1-cycle latency).
//  Sits between the RSA top level (encrypt/decrypt request) and the modulo ROM.
// PARAMETERS
//  n    6  operand/modulus width; ROM product input is 2n bits
//  E_W  6  exponent width; exponent bits scanned MSB first, no leading-zero skip
// PORTS
//  clk          in   1    system clock, all logic on rising edge
//  rst          in   1    asynchronous, active-high reset
//  start        in   1    request pulse; sampled only in IDLE
//  M            in   n    base; any value 0..2^n-1, reduced mod N internally
//  E            in   E_W  exponent
//  N            in   n    modulus, valid 1..2^n-1; 0 is illegal
//  busy         out  1    high from cycle after accepted start until done
//  done         out  1    1-cycle pulse, result valid in same cycle
//  err          out  1    1-cycle pulse instead of done when N==0 at start
//  result       out  n    last result; holds until next done
//  rom_N        out  n    modulus to ROM (latched N_q)
//  rom_mult_out out  2n   product to ROM = a_q * b_q, combinational from regs
//  rom_ram_out  in   n    ROM registered output
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, err=0, result=0; M_q,E_q,N_q,R,a_q,b_q=0.
//  IDLE: start=1 & N!=0 -> latch M,E,N; a_q=M, b_q=1; bit index i=E_W-1;
//    R=(N==1)?0:1; go RED_ISS. start=1 & N==0 -> err pulse next cycle, stay IDLE.
//  Each modmul = ISS cycle (operands stable, ROM samples) + WAIT cycle
//    (rom_ram_out valid, captured at end of WAIT). No other ROM latency allowed.
//  RED_ISS->RED_WAIT: Mr = rom_ram_out (M mod N); -> SQ_ISS with a_q=b_q=R.
//  SQ_ISS->SQ_WAIT: R = rom_ram_out; if E_q[i] -> MUL_ISS with a_q=R, b_q=Mr;
//    else -> NEXT.
//  MUL_ISS->MUL_WAIT: R = rom_ram_out; -> NEXT.
//  NEXT (folded into WAIT transition, no extra cycle): if i==0 -> DONE,
//    else i=i-1, -> SQ_ISS with a_q=b_q=R.
//  DONE: result=R, done=1 for one cycle, busy=0, -> IDLE. start may be accepted
//    the cycle after done.
//  Latency: start accept to done = 2 + 2*E_W + 2*popcount(E) + 1 cycles.
//  E==0: all squares of R (1 or 0) -> result = 1 mod N (1, or 0 if N==1).
//  Product width: a_q,b_q < 2^n so a_q*b_q < 2^(2n); no truncation.
//  start while busy: ignored, inputs not relatched. M,E,N may change while busy.
//  rst mid-operation: immediate abort to IDLE, no done, result cleared to 0.
//  rom_N constant for whole operation (ROM address uses N-1, N!=0 guaranteed).
// TESTING
//  (bench uses behavioural ROM: registered (prod mod N), 1-cycle latency; n=6, E_W=6)
//  M=5,E=3,N=33 -> result=26 (125 mod 33); done exactly 19 cycles after start accept
//  M=40,E=2,N=33 -> base reduced to 7, result=16 (49 mod 33)
//  E=0,N=33 -> result=1; E=0,N=1 -> result=0; M=63,E=63,N=1 -> result=0
//  N=0 with start -> err pulse, no done, busy stays 0, result unchanged
//  start again while busy with different M -> ignored, first result correct
//  rst asserted during SQ_WAIT -> busy/done=0 at once, result=0, next start runs clean

Source files
------------

// File: rtl/modexp_ctrl.sv
// ---------------------------------------------------------------------------
// modexp_ctrl
//   Sequencer computing result = M^E mod N by left-to-right square-and-multiply.
//   An internal n x n multiplier forms every product; each reduction goes
//   through the external modulo lookup ROM, which has a registered output and
//   a one-cycle latency. Every modular multiply therefore takes an ISS cycle
//   (operands stable, ROM samples) followed by a WAIT cycle (ROM output valid,
//   captured at the end of that cycle).
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   start         request pulse, sampled only while idle
//   M, E, N       base, exponent, modulus (N == 0 is rejected with err)
//   busy          high from the cycle after an accepted start until done
//   done          one-cycle pulse, result valid in the same cycle
//   err           one-cycle pulse when start arrives with N == 0
//   result        last result, held until the next done
//   rom_N         latched modulus presented to the ROM
//   rom_mult_out  a_q * b_q presented to the ROM (combinational from registers)
//   rom_ram_out   registered ROM output, (rom_mult_out mod rom_N)
// ---------------------------------------------------------------------------
module modexp_ctrl #(
  parameter int n   = 6,
  parameter int E_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [n-1:0]   M,
  input  logic [E_W-1:0] E,
  input  logic [n-1:0]   N,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [n-1:0]   result,
  output logic [n-1:0]   rom_N,
  output logic [2*n-1:0] rom_mult_out,
  input  logic [n-1:0]   rom_ram_out
);

  localparam int IW = (E_W > 1) ? $clog2(E_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RED_ISS,
    RED_WAIT,
    SQ_ISS,
    SQ_WAIT,
    MUL_ISS,
    MUL_WAIT,
    DONE
  } state_t;

  state_t          state;
  logic [n-1:0]    m_q;
  logic [E_W-1:0]  e_q;
  logic [n-1:0]    n_q;
  logic [n-1:0]    r_q;
  logic [n-1:0]    mr_q;
  logic [n-1:0]    a_q;
  logic [n-1:0]    b_q;
  logic [IW-1:0]   bit_idx;

  // Full-width product; both operands are below 2^n so nothing is truncated.
  assign rom_mult_out = (2*n)'(a_q) * (2*n)'(b_q);
  assign rom_N        = n_q;

  // Main sequencer. The "next bit" step is folded into the WAIT transitions
  // so no cycle is spent between the end of one modmul and the next square.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      m_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
      mr_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bit_idx <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (N == '0) begin
              err <= 1'b1;
            end else begin
              m_q     <= M;
              e_q     <= E;
              n_q     <= N;
              // First step reduces the raw base: M * 1 mod N.
              a_q     <= M;
              b_q     <= n'(1);
              bit_idx <= IW'(E_W - 1);
              // 1 mod N is 0 when N == 1, so the accumulator starts there.
              r_q     <= (N == n'(1)) ? '0 : n'(1);
              busy    <= 1'b1;
              state   <= RED_ISS;
            end
          end
        end

        RED_ISS:  state <= RED_WAIT;

        RED_WAIT: begin
          mr_q  <= rom_ram_out;
          a_q   <= r_q;
          b_q   <= r_q;
          state <= SQ_ISS;
        end

        SQ_ISS:   state <= SQ_WAIT;

        SQ_WAIT: begin
          r_q <= rom_ram_out;
          if (e_q[bit_idx]) begin
            a_q   <= rom_ram_out;
            b_q   <= mr_q;
            state <= MUL_ISS;
          end else if (bit_idx == '0) begin
            state <= DONE;
          end else begin
            bit_idx <= bit_idx - IW'(1);
            a_q     <= rom_ram_out;
            b_q     <= rom_ram_out;
            state   <= SQ_ISS;
          end
        end

        MUL_ISS:  state <= MUL_WAIT;

        MUL_WAIT: begin
          r_q <= rom_ram_out;
          if (bit_idx == '0) begin
            state <= DONE;
          end else begin
            bit_idx <= bit_idx - IW'(1);
            a_q     <= rom_ram_out;
            b_q     <= rom_ram_out;
            state   <= SQ_ISS;
          end
        end

        DONE: begin
          result <= r_q;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_modexp_ctrl
//   Directed self-checking bench for modexp_ctrl (n = 6, E_W = 6). A
//   behavioural ROM returns the registered (product mod N) with one cycle of
//   latency. Expected results and latencies are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_modexp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  M;
  logic [5:0]  E;
  logic [5:0]  N;
  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  result;
  logic [5:0]  rom_N;
  logic [11:0] rom_mult_out;
  logic [5:0]  rom_ram_out;

  int errors = 0;
  int checks = 0;

  modexp_ctrl #(.n(6), .E_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .M            (M),
    .E            (E),
    .N            (N),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .result       (result),
    .rom_N        (rom_N),
    .rom_mult_out (rom_mult_out),
    .rom_ram_out  (rom_ram_out)
  );

  always #5 clk = ~clk;

  // Behavioural modulo ROM: registered output, guarded against N == 0.
  always_ff @(posedge clk) begin
    if (rom_N == 6'd0) rom_ram_out <= 6'd0;
    else               rom_ram_out <= 6'((rom_mult_out % {6'd0, rom_N}));
  end

  // Drives one request and waits (bounded) for done. Counts edges from the
  // accepting edge to the edge after which done is visible.
  task automatic run_op(input logic [5:0] m, input logic [5:0] e, input logic [5:0] nn,
                        output int cycles, output bit seen_done, output bit busy_ok);
    @(negedge clk);
    M = m; E = e; N = nn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0; seen_done = 1'b0; busy_ok = 1'b1;
    while (!seen_done && cycles < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      cycles++;
      if (done === 1'b1) seen_done = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; M = '0; E = '0; N = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%0b exp=0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%0b exp=0", err); end
    checks++; if (result !== 6'd0) begin errors++; $display("[TB] FAIL reset_result got=%0d exp=0", result); end
    checks++; if (rom_N !== 6'd0) begin errors++; $display("[TB] FAIL reset_romN got=%0d exp=0", rom_N); end
    checks++; if (rom_mult_out !== 12'd0) begin errors++; $display("[TB] FAIL reset_prod got=%0d exp=0", rom_mult_out); end
    @(negedge clk); rst = 1'b0;
  endtask

  // Runs one operation and checks result, latency and busy/done behaviour.
  task automatic test_op(input string name, input logic [5:0] m, input logic [5:0] e,
                         input logic [5:0] nn, input logic [5:0] exp_res, input int exp_cyc);
    int cyc; bit seen; bit bok;
    run_op(m, e, nn, cyc, seen, bok);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL %s_done got=timeout exp=done", name); end
    checks++; if (result !== exp_res) begin errors++; $display("[TB] FAIL %s_result got=%0d exp=%0d", name, result, exp_res); end
    checks++; if (cyc != exp_cyc) begin errors++; $display("[TB] FAIL %s_latency got=%0d exp=%0d", name, cyc, exp_cyc); end
    checks++; if (bok !== 1'b1) begin errors++; $display("[TB] FAIL %s_busy_during got=0 exp=1", name); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy_at_done got=%0b exp=0", name, busy); end
  endtask

  task automatic test_result_hold();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (result !== 6'd26) begin errors++; $display("[TB] FAIL hold_result got=%0d exp=26", result); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL hold_done got=%0b exp=0", done); end
  endtask

  task automatic test_err();
    bit stray_done = 1'b0;
    @(negedge clk);
    M = 6'd9; E = 6'd5; N = 6'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_pulse got=%0b exp=1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL err_busy got=%0b exp=0", busy); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_width got=%0b exp=0", err); end
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1 || busy === 1'b1) stray_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (stray_done !== 1'b0) begin errors++; $display("[TB] FAIL err_no_done got=activity exp=idle"); end
    checks++; if (result !== 6'd27) begin errors++; $display("[TB] FAIL err_result got=%0d exp=27", result); end
  endtask

  // Second start with different operands mid-operation must be ignored, and
  // a changed N input must not reach the ROM.
  task automatic test_start_busy();
    int cyc = 0; bit seen = 1'b0;
    @(negedge clk);
    M = 6'd5; E = 6'd3; N = 6'd33; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen && cyc < 200) begin
      if (cyc == 5) begin
        @(negedge clk);
        M = 6'd7; E = 6'd63; N = 6'd40; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
      if (cyc == 8) begin
        checks++; if (rom_N !== 6'd33) begin errors++; $display("[TB] FAIL busy_romN got=%0d exp=33", rom_N); end
      end
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL busy_done got=timeout exp=done"); end
    checks++; if (result !== 6'd26) begin errors++; $display("[TB] FAIL busy_result got=%0d exp=26", result); end
    checks++; if (cyc != 19) begin errors++; $display("[TB] FAIL busy_latency got=%0d exp=19", cyc); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    M = 6'd5; E = 6'd3; N = 6'd33; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Three more edges: RED_ISS -> RED_WAIT -> SQ_ISS -> SQ_WAIT.
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_done got=%0b exp=0", done); end
    checks++; if (result !== 6'd0) begin errors++; $display("[TB] FAIL rstmid_result got=%0d exp=0", result); end
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_op("basic", 6'd5, 6'd3, 6'd33, 6'd26, 19);
    test_result_hold();
    test_op("reduce", 6'd40, 6'd2, 6'd33, 6'd16, 17);
    test_op("ezero", 6'd12, 6'd0, 6'd33, 6'd1, 15);
    test_op("ezero_n1", 6'd12, 6'd0, 6'd1, 6'd0, 15);
    test_op("mod_one", 6'd63, 6'd63, 6'd1, 6'd0, 27);
    test_op("e10", 6'd2, 6'd10, 6'd61, 6'd48, 19);
    test_op("all_ones", 6'd3, 6'd63, 6'd61, 6'd27, 27);
    test_err();
    test_start_busy();
    test_reset_mid();
    test_op("after_rst", 6'd40, 6'd2, 6'd33, 6'd16, 17);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
